icache_miss_handler: RTL and testbench
======================================

Name: icache_miss_handler

Overview:
- Per-thread instruction-cache miss controller, between the fetch-stage tag lookup and main memory.
- On a fetch miss it allocates the thread's miss slot and samples a victim way from cache_lru_mt through the victim port.
- It arbitrates line requests to memory round-robin across threads. On each memory response it writes the line, tag and valid bit into the tag/data arrays and updates LRU through the update_*_mt port.

Parameters:
NUM_THREADS, `THR_PER_CORE, hardware threads / miss slots
NUM_SET, `ICACHE_NUM_SET, cache sets
WAYS_PER_SET, `ICACHE_WAYS_PER_SET, ways per set
TAG_W, `ICACHE_TAG_WIDTH, tag bits
LINE_W, `ICACHE_LINE_WIDTH, line data bits
NUM_SET_W / WAYS_PER_SET_W / THR_W, $clog2 of the above

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high
miss_valid  in  1  fetch reports a miss
miss_ready  out  1  slot of miss_thread is IDLE
miss_thread  in  THR_W  missing thread
miss_set  in  NUM_SET_W  set index
miss_tag  in  TAG_W  tag
victim_req  out  1  to LRU, equals miss_valid&&miss_ready
victim_set  out  NUM_SET_W  to LRU, equals miss_set
victim_way  in  WAYS_PER_SET_W  from LRU, combinational
mem_req_valid  out  1  line request
mem_req_ready  in  1  memory accepts
mem_req_addr  out  TAG_W+NUM_SET_W  line address {tag,set}
mem_req_thread  out  THR_W  requesting thread
mem_rsp_valid  in  1  line returned
mem_rsp_thread  in  THR_W  owner of line
mem_rsp_data  in  LINE_W  line data
fill_valid  out  1  write tag/data arrays
fill_set / fill_way / fill_tag / fill_data  out  widths above  fill location and contents
update_req_mt  out  1  to LRU, equals fill_valid
update_set_mt / update_way_mt / update_thread_mt  out  widths above  equal fill_set / fill_way / fill_thread
fill_thread  out  THR_W  thread to wake in fetch
slot_busy  out  NUM_THREADS  per-thread slot not IDLE, for fetch stall

Behaviour:
- Reset: all slots IDLE. All outputs 0. Round-robin pointer 0. Grant lock cleared.
- Per-slot FSM:
  - IDLE→REQ on miss_valid&&miss_ready. Capture set, tag, and victim_way (sampled the same cycle).
  - REQ→WAIT when the slot is granted and mem_req_ready=1.
  - WAIT→IDLE on mem_rsp_valid with a matching mem_rsp_thread.
- Miss acceptance: at most one miss per cycle. miss_ready is combinational from the slot state of miss_thread; 0 while the slot is REQ or WAIT.
- Arbitration:
  - Round-robin among REQ slots, starting at the pointer.
  - mem_req_valid and its address/thread hold stable while valid&&!ready (grant lock).
  - On handshake the pointer moves to granted+1 mod NUM_THREADS.
  - Earliest request: the cycle after miss acceptance.
- Response:
  - One cycle after mem_rsp_valid, fill_valid=1 for exactly one cycle, with the captured set/way/tag and the registered data. update_req_mt pulses in the same cycle.
  - The slot is IDLE in that fill cycle. A new miss from the same thread may be accepted in the fill cycle.
  - A response for a slot not in WAIT is dropped: no fill, no state change.
- Simultaneous events:
  - Miss accept, memory handshake and response may all occur in one cycle on different slots.
  - Response and miss for the same thread in one cycle: miss rejected (miss_ready=0).
- Victim ownership: mt_mode partitioning in cache_lru_mt keeps MT victims disjoint. In single-threaded mode only thread 0 misses, so there are no victim collisions.
- Reset mid-operation: in-flight slots are discarded. Memory is reset in the same domain, so stale responses are dropped by the not-WAIT rule.

Optional Feature:
- Macro: ICACHE_MISS_HANDLER_STATS_EN.
- When defined:
  - Per-thread 32-bit saturating counters: misses accepted, and total cycles spent in REQ+WAIT.
  - Output ports stat_miss_cnt and stat_lat_cnt [NUM_THREADS][32].
  - Counters clear on reset.
- When undefined: counters and ports are absent; behaviour is otherwise identical.

Decomposition:
- Package icache_pkg:
  - miss_state_t enum {MISS_IDLE, MISS_REQ, MISS_WAIT}.
  - miss_slot_t struct {state, set, tag, way}.
- Sub-module rr_arbiter, parameterised on NUM_REQ: request vector and advance enable in; one-hot grant and index out. Reusable by the dcache.

Test Plan:
- Single miss, thread 0, set 2, tag 0xABC, victim_way=3, ready=1 → mem_req_valid the next cycle with addr {0xABC,2}. A response 5 cycles later gives fill_valid one cycle after it, with set 2 / way 3 / tag 0xABC and update_req_mt=1.
- Threads 0-3 miss on consecutive cycles with ready=1 → grants in order 0,1,2,3. Out-of-order responses 2,0,3,1 → fills in response order, each with its own captured set/way.
- Thread 1 miss while its slot is in WAIT → miss_ready=0, no victim_req.
- mem_req_ready held 0 for 4 cycles while threads 1 and 2 are pending → address/thread stable all 4 cycles. On ready, thread 1 is granted and the pointer becomes 2.
- Response for thread 3 while IDLE → no fill_valid, no update_req_mt.
- Reset asserted while thread 0 is in WAIT → all outputs 0 next cycle. A later response for thread 0 is dropped.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and geometry for the instruction-cache miss path.
// Geometry comes from the core-wide defines, with standalone defaults.
`ifndef THR_PER_CORE
`define THR_PER_CORE 4
`endif
`ifndef ICACHE_NUM_SET
`define ICACHE_NUM_SET 16
`endif
`ifndef ICACHE_WAYS_PER_SET
`define ICACHE_WAYS_PER_SET 4
`endif
`ifndef ICACHE_TAG_WIDTH
`define ICACHE_TAG_WIDTH 16
`endif
`ifndef ICACHE_LINE_WIDTH
`define ICACHE_LINE_WIDTH 64
`endif

package icache_pkg;

    localparam int NUM_THREADS    = `THR_PER_CORE;
    localparam int NUM_SET        = `ICACHE_NUM_SET;
    localparam int WAYS_PER_SET   = `ICACHE_WAYS_PER_SET;
    localparam int TAG_W          = `ICACHE_TAG_WIDTH;
    localparam int LINE_W         = `ICACHE_LINE_WIDTH;
    localparam int NUM_SET_W      = $clog2(NUM_SET);
    localparam int WAYS_PER_SET_W = $clog2(WAYS_PER_SET);
    localparam int THR_W          = $clog2(NUM_THREADS);
    localparam int ADDR_W         = TAG_W + NUM_SET_W;

    typedef enum logic [1:0] {
        MISS_IDLE = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2
    } miss_state_t;

    typedef struct packed {
        miss_state_t                state;
        logic [NUM_SET_W-1:0]       set;
        logic [TAG_W-1:0]           tag;
        logic [WAYS_PER_SET_W-1:0]  way;
    } miss_slot_t;

    function automatic logic [ADDR_W-1:0] line_addr(
        input logic [TAG_W-1:0]     tag,
        input logic [NUM_SET_W-1:0] set
    );
        return {tag, set};
    endfunction

endpackage

// File: rtl/icache_miss_handler_rr_arbiter.sv
// Round-robin arbiter with a grant lock for valid/ready consumers.
// The pointer moves past the winner only when adv signals acceptance.
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               adv,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] lock_idx_q;
    logic             locked_q;
    logic [IDX_W-1:0] pick;
    logic             found;
    int unsigned      cand;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && req[IDX_W'(cand)]) begin
                found = 1'b1;
                pick  = IDX_W'(cand);
            end
        end
    end

    // A stalled winner keeps the grant so the request stays stable.
    assign gnt_idx = (locked_q && req[lock_idx_q]) ? lock_idx_q : pick;
    assign gnt     = (|req) ? (NUM_REQ'(1) << gnt_idx) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q      <= '0;
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
        end else if (adv) begin
            ptr_q    <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            locked_q <= 1'b0;
        end else if (|req) begin
            locked_q   <= 1'b1;
            lock_idx_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/icache_miss_handler.sv
// Per-thread I-cache miss slots, round-robin line requests and fills.
// ICACHE_MISS_HANDLER_STATS_EN adds per-thread miss/latency counters.
module icache_miss_handler
    import icache_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      miss_valid,
    output logic                      miss_ready,
    input  logic [THR_W-1:0]          miss_thread,
    input  logic [NUM_SET_W-1:0]      miss_set,
    input  logic [TAG_W-1:0]          miss_tag,
    output logic                      victim_req,
    output logic [NUM_SET_W-1:0]      victim_set,
    input  logic [WAYS_PER_SET_W-1:0] victim_way,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_W-1:0]         mem_req_addr,
    output logic [THR_W-1:0]          mem_req_thread,
    input  logic                      mem_rsp_valid,
    input  logic [THR_W-1:0]          mem_rsp_thread,
    input  logic [LINE_W-1:0]         mem_rsp_data,
    output logic                      fill_valid,
    output logic [NUM_SET_W-1:0]      fill_set,
    output logic [WAYS_PER_SET_W-1:0] fill_way,
    output logic [TAG_W-1:0]          fill_tag,
    output logic [LINE_W-1:0]         fill_data,
    output logic [THR_W-1:0]          fill_thread,
    output logic                      update_req_mt,
    output logic [NUM_SET_W-1:0]      update_set_mt,
    output logic [WAYS_PER_SET_W-1:0] update_way_mt,
    output logic [THR_W-1:0]          update_thread_mt,
    output logic [NUM_THREADS-1:0]    slot_busy
`ifdef ICACHE_MISS_HANDLER_STATS_EN
    ,
    output logic [31:0]               stat_miss_cnt [NUM_THREADS],
    output logic [31:0]               stat_lat_cnt  [NUM_THREADS]
`endif
);

    miss_slot_t             slot_q [NUM_THREADS];
    miss_slot_t             slot_d [NUM_THREADS];
    logic [NUM_THREADS-1:0] req_vec;
    logic [NUM_THREADS-1:0] gnt_oh;
    logic [THR_W-1:0]       gnt_idx;
    logic                   accept;
    logic                   handshake;
    logic                   rsp_hit;

    assign miss_ready = !reset && (slot_q[miss_thread].state == MISS_IDLE);
    assign accept     = miss_valid && miss_ready;
    assign victim_req = accept;
    assign victim_set = miss_set;

    always_comb begin
        req_vec   = '0;
        slot_busy = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            req_vec[i]   = (slot_q[i].state == MISS_REQ);
            slot_busy[i] = (slot_q[i].state != MISS_IDLE);
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_THREADS)
    ) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (req_vec),
        .adv     (handshake),
        .gnt     (gnt_oh),
        .gnt_idx (gnt_idx)
    );

    assign mem_req_valid  = |req_vec;
    assign handshake      = mem_req_valid && mem_req_ready;
    assign mem_req_thread = mem_req_valid ? gnt_idx : '0;
    assign mem_req_addr   = mem_req_valid
                          ? line_addr(slot_q[gnt_idx].tag, slot_q[gnt_idx].set)
                          : '0;

    // Responses to a slot not waiting on memory are stale and dropped.
    assign rsp_hit = mem_rsp_valid && (slot_q[mem_rsp_thread].state == MISS_WAIT);

    always_comb begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            slot_d[i] = slot_q[i];
            unique case (slot_q[i].state)
                MISS_IDLE: begin
                    if (accept && miss_thread == THR_W'(i)) begin
                        slot_d[i].state = MISS_REQ;
                        slot_d[i].set   = miss_set;
                        slot_d[i].tag   = miss_tag;
                        slot_d[i].way   = victim_way;
                    end
                end
                MISS_REQ: begin
                    if (handshake && gnt_oh[i]) slot_d[i].state = MISS_WAIT;
                end
                MISS_WAIT: begin
                    if (mem_rsp_valid && mem_rsp_thread == THR_W'(i))
                        slot_d[i].state = MISS_IDLE;
                end
                default: slot_d[i].state = MISS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (reset) slot_q[i] <= '0;
            else       slot_q[i] <= slot_d[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !rsp_hit) begin
            fill_valid  <= 1'b0;
            fill_set    <= '0;
            fill_way    <= '0;
            fill_tag    <= '0;
            fill_data   <= '0;
            fill_thread <= '0;
        end else begin
            fill_valid  <= 1'b1;
            fill_set    <= slot_q[mem_rsp_thread].set;
            fill_way    <= slot_q[mem_rsp_thread].way;
            fill_tag    <= slot_q[mem_rsp_thread].tag;
            fill_data   <= mem_rsp_data;
            fill_thread <= mem_rsp_thread;
        end
    end

    assign update_req_mt    = fill_valid;
    assign update_set_mt    = fill_set;
    assign update_way_mt    = fill_way;
    assign update_thread_mt = fill_thread;

`ifdef ICACHE_MISS_HANDLER_STATS_EN
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (reset) begin
                stat_miss_cnt[i] <= '0;
                stat_lat_cnt[i]  <= '0;
            end else begin
                if (accept && miss_thread == THR_W'(i) && stat_miss_cnt[i] != '1)
                    stat_miss_cnt[i] <= stat_miss_cnt[i] + 32'd1;
                if (slot_q[i].state != MISS_IDLE && stat_lat_cnt[i] != '1)
                    stat_lat_cnt[i] <= stat_lat_cnt[i] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_miss_handler.sv
// Bench for icache_miss_handler: directed scenarios then random traffic,
// all cycles checked against a slot/queue reference model.
module tb_icache_miss_handler;
    import icache_pkg::*;

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      miss_valid;
    logic                      miss_ready;
    logic [THR_W-1:0]          miss_thread;
    logic [NUM_SET_W-1:0]      miss_set;
    logic [TAG_W-1:0]          miss_tag;
    logic                      victim_req;
    logic [NUM_SET_W-1:0]      victim_set;
    logic [WAYS_PER_SET_W-1:0] victim_way;
    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [ADDR_W-1:0]         mem_req_addr;
    logic [THR_W-1:0]          mem_req_thread;
    logic                      mem_rsp_valid;
    logic [THR_W-1:0]          mem_rsp_thread;
    logic [LINE_W-1:0]         mem_rsp_data;
    logic                      fill_valid;
    logic [NUM_SET_W-1:0]      fill_set;
    logic [WAYS_PER_SET_W-1:0] fill_way;
    logic [TAG_W-1:0]          fill_tag;
    logic [LINE_W-1:0]         fill_data;
    logic [THR_W-1:0]          fill_thread;
    logic                      update_req_mt;
    logic [NUM_SET_W-1:0]      update_set_mt;
    logic [WAYS_PER_SET_W-1:0] update_way_mt;
    logic [THR_W-1:0]          update_thread_mt;
    logic [NUM_THREADS-1:0]    slot_busy;
`ifdef ICACHE_MISS_HANDLER_STATS_EN
    logic [31:0]               stat_miss_cnt [NUM_THREADS];
    logic [31:0]               stat_lat_cnt  [NUM_THREADS];
`endif

    int checks = 0;
    int errors = 0;

    icache_miss_handler dut (
        .clock            (clock),
        .reset            (reset),
        .miss_valid       (miss_valid),
        .miss_ready       (miss_ready),
        .miss_thread      (miss_thread),
        .miss_set         (miss_set),
        .miss_tag         (miss_tag),
        .victim_req       (victim_req),
        .victim_set       (victim_set),
        .victim_way       (victim_way),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_addr     (mem_req_addr),
        .mem_req_thread   (mem_req_thread),
        .mem_rsp_valid    (mem_rsp_valid),
        .mem_rsp_thread   (mem_rsp_thread),
        .mem_rsp_data     (mem_rsp_data),
        .fill_valid       (fill_valid),
        .fill_set         (fill_set),
        .fill_way         (fill_way),
        .fill_tag         (fill_tag),
        .fill_data        (fill_data),
        .fill_thread      (fill_thread),
        .update_req_mt    (update_req_mt),
        .update_set_mt    (update_set_mt),
        .update_way_mt    (update_way_mt),
        .update_thread_mt (update_thread_mt),
        .slot_busy        (slot_busy)
`ifdef ICACHE_MISS_HANDLER_STATS_EN
        ,
        .stat_miss_cnt    (stat_miss_cnt),
        .stat_lat_cnt     (stat_lat_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: phase 0 = free, 1 = waiting for grant, 2 = outstanding.
    int                        ph   [NUM_THREADS];
    logic [NUM_SET_W-1:0]      mset [NUM_THREADS];
    logic [TAG_W-1:0]          mtag [NUM_THREADS];
    logic [WAYS_PER_SET_W-1:0] mway [NUM_THREADS];
    int                        ptr  = 0;
    int                        lock = -1;
    bit                        started = 0;
    bit                        ef_valid = 0;
    int                        ef_thread;
    logic [NUM_SET_W-1:0]      ef_set;
    logic [WAYS_PER_SET_W-1:0] ef_way;
    logic [TAG_W-1:0]          ef_tag;
    logic [LINE_W-1:0]         ef_data;
    int                        gnt_log[$];
    int                        fill_log[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (lock >= 0) return lock;
        for (int k = 0; k < NUM_THREADS; k++)
            if (ph[(ptr + k) % NUM_THREADS] == 1) return (ptr + k) % NUM_THREADS;
        return -1;
    endfunction

    always @(posedge clock) begin
        int  g;
        int  mt;
        int  rt;
        bit  acc;
        bit  rhit;
        started = 1;
        if (reset) begin
            for (int i = 0; i < NUM_THREADS; i++) ph[i] = 0;
            ptr      = 0;
            lock     = -1;
            ef_valid = 0;
        end else begin
            mt   = int'(miss_thread);
            rt   = int'(mem_rsp_thread);
            acc  = miss_valid && ph[mt] == 0;
            rhit = mem_rsp_valid && ph[rt] == 2;
            g    = model_grant();
            ef_valid = rhit;
            if (rhit) begin
                ef_thread = rt;
                ef_set    = mset[rt];
                ef_way    = mway[rt];
                ef_tag    = mtag[rt];
                ef_data   = mem_rsp_data;
                ph[rt]    = 0;
            end
            if (g >= 0) begin
                if (mem_req_ready) begin
                    ph[g] = 2;
                    ptr   = (g + 1) % NUM_THREADS;
                    lock  = -1;
                end else begin
                    lock = g;
                end
            end
            if (acc) begin
                ph[mt]   = 1;
                mset[mt] = miss_set;
                mtag[mt] = miss_tag;
                mway[mt] = victim_way;
            end
        end
    end

    always @(negedge clock) begin
        int   g;
        logic rdy;
        logic [NUM_THREADS-1:0] busy;
        if (started) begin
            rdy = !reset && ph[miss_thread] == 0;
            chk("miss_ready", miss_ready, rdy);
            chk("victim_req", victim_req, miss_valid && rdy);
            chk("victim_set", victim_set, miss_set);
            g = model_grant();
            chk("mem_req_valid", mem_req_valid, g >= 0);
            if (g >= 0) begin
                chk("mem_req_thread", mem_req_thread, g);
                chk("mem_req_addr", mem_req_addr, {mtag[g], mset[g]});
            end
            chk("fill_valid", fill_valid, ef_valid);
            chk("update_req_mt", update_req_mt, ef_valid);
            if (ef_valid) begin
                chk("fill_thread", fill_thread, ef_thread);
                chk("fill_set", fill_set, ef_set);
                chk("fill_way", fill_way, ef_way);
                chk("fill_tag", fill_tag, ef_tag);
                chk("fill_data", fill_data, ef_data);
                chk("update_set_mt", update_set_mt, ef_set);
                chk("update_way_mt", update_way_mt, ef_way);
                chk("update_thread_mt", update_thread_mt, ef_thread);
            end
            for (int i = 0; i < NUM_THREADS; i++) busy[i] = ph[i] != 0;
            chk("slot_busy", slot_busy, busy);
            if (!reset && mem_req_valid && mem_req_ready) gnt_log.push_back(int'(mem_req_thread));
            if (fill_valid) fill_log.push_back(int'(fill_thread));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic miss(input int t, input int s, input int tg, input int w);
        miss_valid  = 1'b1;
        miss_thread = THR_W'(t);
        miss_set    = NUM_SET_W'(s);
        miss_tag    = TAG_W'(tg);
        victim_way  = WAYS_PER_SET_W'(w);
    endtask

    initial begin
        reset = 1'b1;
        miss_valid = 1'b0; miss_thread = '0; miss_set = '0; miss_tag = '0;
        victim_way = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        mem_rsp_thread = '0; mem_rsp_data = '0;
        repeat (2) step();
        @(negedge clock);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_slot_busy", slot_busy, 0);
        step();
        reset = 1'b0;

        // Single miss, thread 0
        miss(0, 2, 'hABC, 3);
        mem_req_ready = 1'b1;
        @(negedge clock);
        chk("t1_miss_ready", miss_ready, 1);
        chk("t1_victim_req", victim_req, 1);
        step();
        miss_valid = 1'b0;
        @(negedge clock);
        chk("t1_req_valid", mem_req_valid, 1);
        chk("t1_req_addr", mem_req_addr, 20'h0ABC2);
        step();
        repeat (4) step();
        mem_rsp_valid = 1'b1; mem_rsp_thread = '0; mem_rsp_data = 64'h1122334455667788;
        step();
        mem_rsp_valid = 1'b0;
        @(negedge clock);
        chk("t1_fill_valid", fill_valid, 1);
        chk("t1_fill_set", fill_set, 2);
        chk("t1_fill_way", fill_way, 3);
        chk("t1_fill_tag", fill_tag, 'hABC);
        chk("t1_update_req", update_req_mt, 1);
        step();
        @(negedge clock);
        chk("t1_fill_once", fill_valid, 0);

        // Four threads back to back, out-of-order responses
        gnt_log.delete();
        fill_log.delete();
        for (int t = 0; t < 4; t++) begin
            miss(t, 4 + t, 'h100 + t, t);
            step();
        end
        miss_valid = 1'b0;
        repeat (3) step();
        chk("t2_grant_cnt", gnt_log.size(), 4);
        for (int t = 0; t < 4 && t < gnt_log.size(); t++) chk("t2_grant_order", gnt_log[t], t);
        mem_rsp_valid = 1'b1; mem_rsp_thread = 2'd2; mem_rsp_data = 64'hD2;
        step();
        mem_rsp_thread = 2'd0; mem_rsp_data = 64'hD0;
        @(negedge clock);
        chk("t2_fill2_set", fill_set, 6);
        chk("t2_fill2_way", fill_way, 2);
        step();
        mem_rsp_valid = 1'b0;
        // Thread 1 still outstanding: its new miss must be refused
        miss(1, 9, 'h555, 0);
        @(negedge clock);
        chk("t3_miss_ready", miss_ready, 0);
        chk("t3_victim_req", victim_req, 0);
        step();
        miss_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_thread = 2'd3; mem_rsp_data = 64'hD3;
        step();
        mem_rsp_thread = 2'd1; mem_rsp_data = 64'hD1;
        step();
        mem_rsp_valid = 1'b0;
        repeat (2) step();
        chk("t2_fill_cnt", fill_log.size(), 4);
        if (fill_log.size() == 4) begin
            chk("t2_fill_ord0", fill_log[0], 2);
            chk("t2_fill_ord1", fill_log[1], 0);
            chk("t2_fill_ord2", fill_log[2], 3);
            chk("t2_fill_ord3", fill_log[3], 1);
        end

        // Stalled memory: request held stable, then pointer moves to 2
        mem_req_ready = 1'b0;
        miss(1, 9, 'h111, 1);
        step();
        miss(2, 10, 'h222, 2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("t4_hold_valid", mem_req_valid, 1);
            chk("t4_hold_thread", mem_req_thread, 1);
            chk("t4_hold_addr", mem_req_addr, 20'h01119);
            step();
            if (k == 0) miss(0, 11, 'h333, 3);
            else miss_valid = 1'b0;
        end
        mem_req_ready = 1'b1;
        @(negedge clock);
        chk("t4_grant1", mem_req_thread, 1);
        step();
        @(negedge clock);
        chk("t4_grant2", mem_req_thread, 2);
        step();
        @(negedge clock);
        chk("t4_grant0", mem_req_thread, 0);
        step();
        mem_rsp_valid = 1'b1;
        for (int t = 0; t < 3; t++) begin
            mem_rsp_thread = THR_W'(t);
            mem_rsp_data = LINE_W'(64'hE0 + t);
            step();
        end
        mem_rsp_valid = 1'b0;
        step();

        // Stale response for an idle slot
        mem_rsp_valid = 1'b1; mem_rsp_thread = 2'd3;
        step();
        mem_rsp_valid = 1'b0;
        @(negedge clock);
        chk("t5_no_fill", fill_valid, 0);
        chk("t5_no_update", update_req_mt, 0);

        // Reset while thread 0 is outstanding
        miss(0, 7, 'h777, 1);
        step();
        miss_valid = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
        @(negedge clock);
        chk("t6_rst_req_valid", mem_req_valid, 0);
        chk("t6_rst_miss_ready", miss_ready, 0);
        chk("t6_rst_fill_valid", fill_valid, 0);
        chk("t6_rst_slot_busy", slot_busy, 0);
        chk("t6_rst_req_addr", mem_req_addr, 0);
        reset = 1'b0;
        step();
        mem_rsp_valid = 1'b1; mem_rsp_thread = '0;
        step();
        mem_rsp_valid = 1'b0;
        @(negedge clock);
        chk("t6_stale_fill", fill_valid, 0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            miss_valid     = ($urandom_range(0, 2) == 0);
            miss_thread    = THR_W'($urandom_range(0, NUM_THREADS - 1));
            miss_set       = NUM_SET_W'($urandom);
            miss_tag       = TAG_W'($urandom);
            victim_way     = WAYS_PER_SET_W'($urandom);
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            mem_rsp_valid  = ($urandom_range(0, 2) == 0);
            mem_rsp_thread = THR_W'($urandom_range(0, NUM_THREADS - 1));
            mem_rsp_data   = {$urandom, $urandom};
            reset          = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0; miss_valid = 1'b0; mem_rsp_valid = 1'b0;
        step();
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
